sr_cmd_arbiter: RTL and testbench
=================================

// Module: sr_cmd_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer that shares a bank of NUM_FLAGS SR flip-flops between NUM_REQ requesters.
//  Each requester asks to set or clear one flag. The block grants one request at a time.
//  It drives a clean s or r pulse of PULSE_CYCLES clocks to the flop bank, then acks with done.
//  Guarantees the SR bank never sees s=1 and r=1 together on any bit.
// PARAMETERS
//  NUM_REQ       4  number of requesters (>=2)
//  NUM_FLAGS     8  number of SR flops in the driven bank
//  PULSE_CYCLES  2  width of each s/r pulse in clocks (>=1)
//  IDXW          $clog2(NUM_FLAGS), min 1: flag index width (derived, not overridden)
// PORTS
//  clk        in   1              rising-edge clock
//  reset      in   1              asynchronous, active-low reset (0 = in reset)
//  req        in   NUM_REQ        request per requester; held until gnt
//  op         in   NUM_REQ        per requester: 1 = set, 0 = clear
//  idx        in   NUM_REQ*IDXW   per requester flag index; slice i = idx[i*IDXW +: IDXW]
//  gnt        out  NUM_REQ        one-hot, 1-cycle grant pulse
//  done       out  NUM_REQ        one-hot, 1-cycle completion pulse
//  s_out      out  NUM_FLAGS      set pulses to SR bank
//  r_out      out  NUM_FLAGS      reset pulses to SR bank
//  busy       out  1              high in any state other than IDLE
// BEHAVIOUR
//  Reset (reset=0): all outputs 0 immediately; FSM=IDLE; last_gnt=NUM_REQ-1, so req[0] has top priority after release.
//  All outputs are registered.
//  FSM states:
//   IDLE:  if |req, pick the first set req scanning from (last_gnt+1) mod NUM_REQ upward with wrap.
//          Latch winner id, op, idx. Assert gnt[winner] next cycle. Go to DRIVE. Update last_gnt=winner.
//   DRIVE: op=1 -> s_out[idx]=1; op=0 -> r_out[idx]=1. Hold for exactly PULSE_CYCLES cycles (down-counter).
//          Other bits stay 0. gnt is high only on the first DRIVE cycle.
//   DONE:  s_out=r_out=0; done[winner]=1 for 1 cycle. Next state is IDLE.
//  Latency from req sampled in IDLE:
//   gnt at +1, pulse on +1..+PULSE_CYCLES, done at +PULSE_CYCLES+1.
//   Next grant no earlier than the cycle after done.
//  Handshake:
//   A requester may drop req before gnt; the request is withdrawn with no side effect.
//   req/op/idx are sampled only in IDLE; changes after the grant are ignored.
//   A requester may re-request in the cycle done is seen; it competes normally.
//  Fairness: a requester that holds req is granted within NUM_REQ arbitrations.
//  Out-of-range idx (>= NUM_FLAGS): granted, no s/r bit pulses, done still at the normal latency.
//  s_out & r_out == 0 at all times.
//  Reset mid-operation: pulse and pending done are aborted at once; no done is issued for the aborted grant.
//  busy = (state != IDLE).
// CONFIGURATION
//  SR_CMD_SHADOW_EN defined:
//   - Adds output flag_state[NUM_FLAGS], a shadow of the bank; reset value 0.
//   - flag_state updates on the last DRIVE cycle.
//   - A command that would not change the flag (set when 1, clear when 0) skips DRIVE: no pulse, DONE follows the grant cycle.
//  SR_CMD_SHADOW_EN undefined:
//   - No flag_state port.
//   - Every granted in-range command pulses for PULSE_CYCLES cycles.
// TESTING  (NUM_REQ=4, NUM_FLAGS=8, PULSE_CYCLES=2)
//  1 reset=0 with random inputs -> gnt=done=0, s_out=r_out=8'h00, busy=0.
//    After release, req=4'b1111 -> gnt=4'b0001 first.
//  2 req[1]=1, op[1]=1, idx[1]=3 -> gnt=4'b0010 at +1; s_out=8'h08 for 2 cycles; r_out=0 throughout; done=4'b0010 at +3.
//  3 req[0] and req[2] held continuously, both clear idx 6 -> grant order 0,2,0,2; each r_out=8'h40 pulse separated by DONE.
//    Never both s_out and r_out are set.
//  4 reset=0 during the 1st DRIVE cycle of a set on idx 0 -> s_out=0 asynchronously, no done.
//    After release, the still-held req is re-granted starting priority at req[0].
//  5 idx=4'd9 on IDXW=3 is unrepresentable, so use NUM_FLAGS=6 with idx=7 -> gnt at +1, s_out/r_out=0, done at +3.
//  6 SR_CMD_SHADOW_EN: set idx 5 twice -> first: pulse and flag_state=8'h20;
//    second: no pulse, done 1 cycle after gnt, flag_state unchanged.

Source files
------------

// File: rtl/sr_cmd_arbiter.sv
// sr_cmd_arbiter
//   Round-robin arbiter that shares a bank of NUM_FLAGS SR flops between
//   NUM_REQ requesters. One command is granted at a time and turned into a
//   clean s or r pulse of PULSE_CYCLES clocks, followed by a done pulse.
//   s_out and r_out are never high on the same bit.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   req        request per requester, held until gnt
//   op         per requester: 1 = set, 0 = clear
//   idx        per requester flag index, slice i = idx[i*IDXW +: IDXW]
//   gnt        one-hot, 1-cycle grant pulse (first DRIVE cycle)
//   done       one-hot, 1-cycle completion pulse
//   s_out      set pulses to the SR bank
//   r_out      reset pulses to the SR bank
//   flag_state shadow copy of the bank (only with SR_CMD_SHADOW_EN)
//   busy       high whenever the FSM is not idle
//
// Build option
//   SR_CMD_SHADOW_EN : adds flag_state and skips the pulse for commands that
//                      would not change the flag.
//
// State table
//   state    | meaning
//   ST_IDLE  | waiting; arbitrates among req every cycle
//   ST_DRIVE | s/r pulse on the latched flag; gnt on the first cycle
//   ST_DONE  | outputs quiet, done pulse to the winner
module sr_cmd_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int NUM_FLAGS    = 8,
  parameter int PULSE_CYCLES = 2,
  localparam int IDXW        = (NUM_FLAGS > 1) ? $clog2(NUM_FLAGS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ-1:0]      op,
  input  logic [NUM_REQ*IDXW-1:0] idx,
  output logic [NUM_REQ-1:0]      gnt,
  output logic [NUM_REQ-1:0]      done,
  output logic [NUM_FLAGS-1:0]    s_out,
  output logic [NUM_FLAGS-1:0]    r_out,
`ifdef SR_CMD_SHADOW_EN
  output logic [NUM_FLAGS-1:0]    flag_state,
`endif
  output logic                    busy
);

  localparam int RIDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNTW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [RIDW-1:0]     last_q;
  logic [RIDW-1:0]     win_q;
  logic                op_q;
  logic [IDXW-1:0]     idx_q;
  logic [CNTW-1:0]     cnt_q;

  logic                pick_valid;
  logic [RIDW-1:0]     pick_id;
  logic [RIDW:0]       cand;
  logic                cmd_op;
  logic [IDXW-1:0]     cmd_idx;
  logic [NUM_FLAGS-1:0] dec;
  logic                skip_d;

  logic [NUM_REQ-1:0]   gnt_d, done_d;
  logic [NUM_FLAGS-1:0] s_d, r_d;

  // Round-robin scan starting just after the last winner. cand is one bit
  // wider than an id so the wrap needs only a single subtraction.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_q} + (RIDW+1)'(k);
      if (cand >= (RIDW+1)'(NUM_REQ))
        cand = cand - (RIDW+1)'(NUM_REQ);
      if (!pick_valid && req[cand[RIDW-1:0]]) begin
        pick_valid = 1'b1;
        pick_id    = cand[RIDW-1:0];
      end
    end
  end

  // In IDLE the command comes straight from the winner so the pulse can be
  // registered on the same edge as the grant; afterwards the latched copy.
  always_comb begin
    cmd_op  = op_q;
    cmd_idx = idx_q;
    if (state_q == ST_IDLE) begin
      cmd_op  = op[pick_id];
      cmd_idx = idx[pick_id*IDXW +: IDXW];
    end
  end

  // Out-of-range indices decode to all zeros, so they never pulse.
  always_comb begin
    dec = '0;
    for (int f = 0; f < NUM_FLAGS; f++)
      dec[f] = (cmd_idx == IDXW'(f));
  end

`ifdef SR_CMD_SHADOW_EN
  logic                 skip_q;
  logic [NUM_FLAGS-1:0] flag_q;
  logic                 noop;

  assign noop   = |(dec & (cmd_op ? flag_q : ~flag_q));
  assign skip_d = (state_q == ST_IDLE) ? noop : skip_q;
`else
  assign skip_d = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (pick_valid) state_d = ST_DRIVE;
      ST_DRIVE: if (cnt_q == '0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs. A skipped (no-op) command still
  // spends its grant cycle in DRIVE, with the pulse masked.
  always_comb begin
    gnt_d  = '0;
    done_d = '0;
    s_d    = '0;
    r_d    = '0;
    if (state_q == ST_IDLE && pick_valid)
      gnt_d[pick_id] = 1'b1;
    if (state_q == ST_DRIVE && cnt_q == '0)
      done_d[win_q] = 1'b1;
    if (state_d == ST_DRIVE && !skip_d) begin
      if (cmd_op) s_d = dec;
      else        r_d = dec;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      last_q  <= RIDW'(NUM_REQ-1);
      win_q   <= '0;
      op_q    <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      gnt     <= '0;
      done    <= '0;
      s_out   <= '0;
      r_out   <= '0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt     <= gnt_d;
      done    <= done_d;
      s_out   <= s_d;
      r_out   <= r_d;
      busy    <= (state_d != ST_IDLE);
      if (state_q == ST_IDLE && pick_valid) begin
        win_q  <= pick_id;
        last_q <= pick_id;
        op_q   <= cmd_op;
        idx_q  <= cmd_idx;
        cnt_q  <= skip_d ? '0 : CNTW'(PULSE_CYCLES-1);
      end else if (state_q == ST_DRIVE && cnt_q != '0) begin
        cnt_q <= cnt_q - CNTW'(1);
      end
    end
  end

`ifdef SR_CMD_SHADOW_EN
  // Shadow follows the bank on the last DRIVE edge of a real pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      skip_q <= 1'b0;
      flag_q <= '0;
    end else begin
      if (state_q == ST_IDLE && pick_valid)
        skip_q <= noop;
      if (state_q == ST_DRIVE && cnt_q == '0 && !skip_q)
        flag_q <= op_q ? (flag_q | dec) : (flag_q & ~dec);
    end
  end

  assign flag_state = flag_q;
`endif

endmodule

// File: tb/tb_sr_cmd_arbiter.sv
`timescale 1ns/1ps
module tb_sr_cmd_arbiter;
  localparam int NR = 4;
  localparam int NF = 8;
  localparam int PC = 2;
  localparam int IW = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req, op;
  logic [11:0] idx;
  logic [3:0]  gnt, done;
  logic [7:0]  s_out, r_out;
  logic        busy;

  logic [3:0]  req_b, op_b;
  logic [11:0] idx_b;
  logic [3:0]  gnt_b, done_b;
  logic [5:0]  s_b, r_b;
  logic        busy_b;

`ifdef SR_CMD_SHADOW_EN
  logic [7:0]  flag_state;
  logic [5:0]  flag_b;
`endif

  sr_cmd_arbiter #(.NUM_REQ(NR), .NUM_FLAGS(NF), .PULSE_CYCLES(PC)) dut (
    .clk(clk), .reset(reset), .req(req), .op(op), .idx(idx),
    .gnt(gnt), .done(done), .s_out(s_out), .r_out(r_out),
`ifdef SR_CMD_SHADOW_EN
    .flag_state(flag_state),
`endif
    .busy(busy)
  );

  sr_cmd_arbiter #(.NUM_REQ(NR), .NUM_FLAGS(6), .PULSE_CYCLES(PC)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .op(op_b), .idx(idx_b),
    .gnt(gnt_b), .done(done_b), .s_out(s_b), .r_out(r_b),
`ifdef SR_CMD_SHADOW_EN
    .flag_state(flag_b),
`endif
    .busy(busy_b)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1);
  end

  // ---------------- reference model (timeline of expected outputs) -------
  typedef struct {
    logic [3:0] gnt;
    logic [3:0] done;
    logic [7:0] s;
    logic [7:0] r;
    logic       busy;
    logic [7:0] fs;
  } exp_t;

  exp_t       q[$];
  int         m_last;
  logic [7:0] m_flags;

  task automatic model_reset();
    q.delete();
    m_last  = NR - 1;
    m_flags = '0;
  endtask

  // Called at each active edge the DUT is out of reset. When idle, the
  // command sampled now lays out its whole future timeline in q.
  task automatic model_edge();
    int w, ix, len;
    logic o, nop;
    logic [7:0] fs_old;
    exp_t e;
    if (q.size() == 0 && req != 4'b0) begin
      w = -1;
      for (int j = 1; j <= NR; j++)
        if (w < 0 && req[(m_last + j) % NR]) w = (m_last + j) % NR;
      m_last = w;
      o   = op[w];
      ix  = int'(idx[w*IW +: IW]);
      nop = 1'b0;
`ifdef SR_CMD_SHADOW_EN
      nop = (m_flags[ix] == o);
`endif
      fs_old = m_flags;
      if (!nop) m_flags[ix] = o;
      len = nop ? 1 : PC;
      for (int c = 0; c < len; c++) begin
        e = '{default: 0};
        e.gnt  = (c == 0) ? 4'(1 << w) : 4'b0;
        e.s    = (!nop && o)  ? 8'(1 << ix) : 8'b0;
        e.r    = (!nop && !o) ? 8'(1 << ix) : 8'b0;
        e.busy = 1'b1;
        e.fs   = fs_old;
        q.push_back(e);
      end
      e = '{default: 0};
      e.done = 4'(1 << w);
      e.busy = 1'b1;
      e.fs   = m_flags;
      q.push_back(e);
      e = '{default: 0};
      e.fs = m_flags;
      q.push_back(e);
    end
  endtask

  task automatic model_expect(output exp_t e);
    if (q.size() > 0) e = q.pop_front();
    else begin
      e = '{default: 0};
      e.fs = m_flags;
    end
  endtask

  // ---------------- directed helpers --------------------------------------
  typedef struct {
    logic [3:0]  req;
    logic [3:0]  op;
    logic [11:0] idx;
    logic [3:0]  gnt;
    logic [7:0]  s;
    logic [7:0]  r;
    logic        nop;   // command is a no-op when the shadow is built in
  } vec_t;

  task automatic check_zero(input string tag);
    chk({tag, "_gnt"},  32'(gnt),   32'h0);
    chk({tag, "_done"}, 32'(done),  32'h0);
    chk({tag, "_s"},    32'(s_out), 32'h0);
    chk({tag, "_r"},    32'(r_out), 32'h0);
    chk({tag, "_busy"}, 32'(busy),  32'h0);
`ifdef SR_CMD_SHADOW_EN
    chk({tag, "_flag"}, 32'(flag_state), 32'h0);
`endif
  endtask

  task automatic do_reset(input string tag);
    #2 reset = 1'b0;
    #1 check_zero({tag, "_async"});
    @(posedge clk); #1;
    check_zero({tag, "_held"});
    reset = 1'b1;
  endtask

  // Drives one command and checks the full timeline through the idle cycle.
  task automatic apply_vec(input vec_t v, input string tag);
    int len;
    logic skip;
    skip = 1'b0;
`ifdef SR_CMD_SHADOW_EN
    skip = v.nop;
`endif
    len = skip ? 1 : PC;
    req = v.req; op = v.op; idx = v.idx;
    for (int c = 1; c <= len + 2; c++) begin
      @(posedge clk); #1;
      chk({tag, "_gnt"},  32'(gnt),   (c == 1) ? 32'(v.gnt) : 32'h0);
      chk({tag, "_s"},    32'(s_out), (c <= len && !skip) ? 32'(v.s) : 32'h0);
      chk({tag, "_r"},    32'(r_out), (c <= len && !skip) ? 32'(v.r) : 32'h0);
      chk({tag, "_done"}, 32'(done),  (c == len + 1) ? 32'(v.gnt) : 32'h0);
      chk({tag, "_busy"}, 32'(busy),  (c <= len + 1) ? 32'h1 : 32'h0);
    end
  endtask

  task automatic apply_b(input logic [3:0] rq, input logic [3:0] o, input logic [11:0] ix,
                         input logic [3:0] eg, input logic [5:0] es, input string tag);
    req_b = rq; op_b = o; idx_b = ix;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      chk({tag, "_gnt"},  32'(gnt_b),  (c == 1) ? 32'(eg) : 32'h0);
      chk({tag, "_s"},    32'(s_b),    (c <= 2) ? 32'(es) : 32'h0);
      chk({tag, "_r"},    32'(r_b),    32'h0);
      chk({tag, "_done"}, 32'(done_b), (c == 3) ? 32'(eg) : 32'h0);
    end
    req_b = '0;
  endtask

  vec_t vecs[10];
  exp_t e;

  initial begin
    vecs[0] = '{4'b1111, 4'b1111, 12'h000, 4'b0001, 8'h01, 8'h00, 1'b0};
    vecs[1] = '{4'b0010, 4'b0010, 12'h018, 4'b0010, 8'h08, 8'h00, 1'b0};
    vecs[2] = '{4'b1000, 4'b0000, 12'h400, 4'b1000, 8'h00, 8'h04, 1'b1};
    vecs[3] = '{4'b0101, 4'b0000, 12'h186, 4'b0001, 8'h00, 8'h40, 1'b1};
    vecs[4] = '{4'b0101, 4'b0000, 12'h186, 4'b0100, 8'h00, 8'h40, 1'b1};
    vecs[5] = '{4'b0101, 4'b0000, 12'h186, 4'b0001, 8'h00, 8'h40, 1'b1};
    vecs[6] = '{4'b0101, 4'b0000, 12'h186, 4'b0100, 8'h00, 8'h40, 1'b1};
    vecs[7] = '{4'b1010, 4'b0010, 12'h238, 4'b1000, 8'h00, 8'h02, 1'b1};
    vecs[8] = '{4'b1010, 4'b0010, 12'h238, 4'b0010, 8'h80, 8'h00, 1'b0};
    vecs[9] = '{4'b1111, 4'b0101, 12'hB6D, 4'b0100, 8'h20, 8'h00, 1'b0};

    reset = 1'b1;
    req = '0; op = '0; idx = '0;
    req_b = '0; op_b = '0; idx_b = '0;

    // reset with random inputs applied
    req = 4'($urandom); op = 4'($urandom); idx = 12'($urandom);
    do_reset("rst1");
    req = '0;
    @(posedge clk); #1;

    // reset during the first DRIVE cycle aborts the pulse and the done
    req = 4'b0001; op = 4'b0001; idx = 12'h000;
    @(posedge clk); #1;
    chk("abort_gnt", 32'(gnt), 32'h1);
    chk("abort_s",   32'(s_out), 32'h01);
    #2 reset = 1'b0;
    #1;
    chk("abort_s_async", 32'(s_out), 32'h0);
    chk("abort_busy",    32'(busy),  32'h0);
    req = 4'b0011; op = 4'b0011; idx = 12'h000;
    @(posedge clk); #1;
    chk("abort_nodone0", 32'(done), 32'h0);
    @(posedge clk); #1;
    chk("abort_nodone1", 32'(done), 32'h0);
    reset = 1'b1;
    apply_vec('{4'b0011, 4'b0011, 12'h000, 4'b0001, 8'h01, 8'h00, 1'b0}, "regrant");

    // table of single commands; round-robin state carries across records
    do_reset("rst2");
    for (int i = 0; i < 10; i++)
      apply_vec(vecs[i], $sformatf("vec%0d", i));
    req = '0;

    // out-of-range index on a 6-flag bank, then an in-range one
    apply_b(4'b0001, 4'b0001, 12'h007, 4'b0001, 6'h00, "oor");
    apply_b(4'b0010, 4'b0010, 12'h028, 4'b0010, 6'h20, "b_in");

`ifdef SR_CMD_SHADOW_EN
    do_reset("rst3");
    apply_vec('{4'b0100, 4'b0100, 12'h140, 4'b0100, 8'h20, 8'h00, 1'b0}, "sh_set1");
    chk("sh_flag1", 32'(flag_state), 32'h20);
    apply_vec('{4'b0100, 4'b0100, 12'h140, 4'b0100, 8'h20, 8'h00, 1'b1}, "sh_set2");
    chk("sh_flag2", 32'(flag_state), 32'h20);
    req = '0;
`endif

    // randomized traffic against the model, with occasional resets
    do_reset("rst4");
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      if ($urandom_range(0, 3) == 0) op  = 4'($urandom);
      if ($urandom_range(0, 3) == 0) idx = 12'($urandom);
      @(posedge clk);
      model_edge();
      #1;
      model_expect(e);
      chk("rnd_gnt",  32'(gnt),   32'(e.gnt));
      chk("rnd_done", 32'(done),  32'(e.done));
      chk("rnd_s",    32'(s_out), 32'(e.s));
      chk("rnd_r",    32'(r_out), 32'(e.r));
      chk("rnd_busy", 32'(busy),  32'(e.busy));
      chk("rnd_sr_overlap", 32'(s_out & r_out), 32'h0);
`ifdef SR_CMD_SHADOW_EN
      chk("rnd_flag", 32'(flag_state), 32'(e.fs));
`endif
      if ($urandom_range(0, 249) == 0) begin
        do_reset("rnd_rst");
        model_reset();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
